// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, instruction field layout, syscall word.
// The HALT state only exists when IFU_HALT_EN is defined.
package cpu_pkg;

    `ifdef IFU_HALT_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;
    `else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1
    } fetch_state_e;
    `endif

    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Sign-extended word offset of a branch, already scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection from the decoder's branch/jump decisions and the ALU zero flag.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_out,
    input  logic [31:0] instr,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc4_s;
    logic [31:0] jump_target_s;
    logic [31:0] branch_target_s;
    logic        taken_s;

    assign pc4_s           = pc_out + 32'd4;
    assign jump_target_s   = {pc4_s[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    assign branch_target_s = pc4_s + branch_offset(instr[IMM16_MSB:IMM16_LSB]);
    assign taken_s         = (branch_eq & zero) | (branch_ne & ~zero);

    // Jump outranks any branch decision.
    always_comb begin
        next_pc = pc4_s;
        if (jump) begin
            next_pc = jump_target_s;
        end else if (taken_s) begin
            next_pc = branch_target_s;
        end else begin
            next_pc = pc4_s;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, imem request/ack, valid/ready issue to the datapath, next-PC update.
// Defining IFU_HALT_EN makes an accepted syscall park the unit in HALT until reset.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    output logic        halted
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  pc_out_r;
    logic [31:0]  npc_s;
    logic         req_r;
    logic         valid_r;
    logic         fetch_done_s;
    logic         handshake_s;

    assign fetch_done_s = (state_r == ST_FETCH) && imem_ack;
    assign handshake_s  = (state_r == ST_ISSUE) && instr_ready;

    npc_calc u_npc_calc (
        .pc_out    (pc_out_r),
        .instr     (instr_r),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .jump      (jump),
        .zero      (zero),
        .next_pc   (npc_s)
    );

    // Next-state selection for the fetch/issue handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    `ifdef IFU_HALT_EN
                    if (instr_r == SYSCALL_WORD) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                    `else
                    state_next_s = ST_FETCH;
                    `endif
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            `ifdef IFU_HALT_EN
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            `endif
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // State register; the Moore outputs are registered from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            req_r   <= (state_next_s == ST_FETCH);
            valid_r <= (state_next_s == ST_ISSUE);
        end
    end

    // PC and instruction holding registers; PC moves only on an accepted instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r     <= {RESET_PC[31:2], 2'b00};
            instr_r  <= 32'h0000_0000;
            pc_out_r <= 32'h0000_0000;
        end else begin
            if (fetch_done_s) begin
                instr_r  <= imem_rdata;
                pc_out_r <= pc_r;
            end
            if (handshake_s) begin
                pc_r <= npc_s;
            end
        end
    end

    `ifdef IFU_HALT_EN
    logic halted_r;

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_next_s == ST_HALT);
        end
    end

    assign halted = halted_r;
    `else
    assign halted = 1'b0;
    `endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign pc_out      = pc_out_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected fetch addresses and issued
// instructions into queues, an independent monitor pops and compares as the DUT presents them.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        zero;
    logic        halted;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .zero        (zero),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_fetch_q[$];
    logic [63:0] exp_issue_q[$];
    logic [31:0] model_pc;
    logic        halt_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] word,
                                            input logic beq, input logic bne,
                                            input logic j, input logic z);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | ({6'd0, word[25:0]} * 32'd4);
        if ((beq && z) || (bne && !z)) begin
            off = $signed(word[15:0]);
            return pc4 + 32'(off * 4);
        end
        return pc4;
    endfunction

    function automatic logic [31:0] jw(input logic [25:0] t26);
        return {6'h02, t26};
    endfunction

    function automatic logic [31:0] bw(input logic [15:0] imm);
        return {16'h1022, imm};
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SYSCALL_WORD) w = 32'h0000_0020;
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares what the DUT presents against the queued expectations.
    initial begin
        logic        pr;
        logic        pv;
        logic [31:0] ha;
        logic [31:0] hi;
        logic [31:0] hp;
        logic [63:0] e;
        pr = 1'b0;
        pv = 1'b0;
        ha = 32'd0;
        hi = 32'd0;
        hp = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pr = 1'b0;
                pv = 1'b0;
            end else begin
                chk("req_valid_exclusive", {31'd0, imem_req & instr_valid}, 32'd0);
                chk("halted", {31'd0, halted}, {31'd0, halt_exp});
                if (imem_req) begin
                    if (!pr) begin
                        if (exp_fetch_q.size() == 0) begin
                            chk("fetch_unexpected", imem_addr, 32'hDEAD_BEEF);
                        end else begin
                            chk("fetch_addr", imem_addr, exp_fetch_q.pop_front());
                        end
                        ha = imem_addr;
                    end else begin
                        chk("addr_stable", imem_addr, ha);
                    end
                end
                if (instr_valid) begin
                    if (!pv) begin
                        if (exp_issue_q.size() == 0) begin
                            chk("issue_unexpected", pc_out, 32'hDEAD_BEEF);
                        end else begin
                            e = exp_issue_q.pop_front();
                            chk("issue_pc", pc_out, e[63:32]);
                            chk("issue_instr", instr, e[31:0]);
                        end
                        hi = instr;
                        hp = pc_out;
                    end else begin
                        chk("instr_stable", instr, hi);
                        chk("pc_out_stable", pc_out, hp);
                    end
                end
                pr = imem_req;
                pv = instr_valid;
            end
        end
    end

    task automatic do_reset(input int cycles, input logic ack_in_reset);
        exp_fetch_q.delete();
        exp_issue_q.delete();
        halt_exp    = 1'b0;
        rst_n       = 1'b0;
        imem_ack    = ack_in_reset;
        imem_rdata  = $urandom;
        instr_ready = 1'($urandom);
        repeat (cycles) tick();
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, RST_PC);
        rst_n       = 1'b1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        model_pc    = RST_PC;
        exp_fetch_q.push_back(RST_PC);
        tick();
    endtask

    task automatic do_instr(input logic [31:0] word, input logic beq, input logic bne,
                            input logic j, input logic z, input int lat, input int rdy,
                            input logic use_exp, input logic [31:0] exp_next);
        logic [31:0] nxt;
        logic        hlt;
        chk("req_on_fetch", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;
        for (int i = 0; i < lat; i++) begin
            instr_ready = 1'($urandom);
            imem_rdata  = $urandom;
            tick();
            chk("no_valid_while_waiting", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'($urandom);
        exp_issue_q.push_back({model_pc, word});
        tick();
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        branch_eq   = beq;
        branch_ne   = bne;
        jump        = j;
        zero        = z;
        instr_ready = 1'b0;
        for (int i = 0; i < rdy; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            tick();
        end
        nxt = use_exp ? exp_next : ref_npc(model_pc, word, beq, bne, j, z);
        hlt = 1'b0;
        `ifdef IFU_HALT_EN
        hlt = (word == SYSCALL_WORD);
        `endif
        if (hlt) halt_exp = 1'b1;
        else     exp_fetch_q.push_back(nxt);
        model_pc    = nxt;
        instr_ready = 1'b1;
        imem_ack    = 1'($urandom);
        tick();
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        branch_eq   = 1'($urandom);
        branch_ne   = 1'($urandom);
        jump        = 1'($urandom);
        zero        = 1'($urandom);
    endtask

    // Stimulus: directed address/branch cases, randomized traffic, syscall and mid-fetch reset.
    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        branch_eq   = 1'b0;
        branch_ne   = 1'b0;
        jump        = 1'b0;
        zero        = 1'b0;
        do_reset(3, 1'b0);

        for (int i = 0; i < 3; i++)
            do_instr(rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, RST_PC + 32'(4 * (i + 1)));
        do_instr(rnd_word(),  1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 32'h0000_3010);
        do_instr(bw(16'hFFFC), 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 32'h0000_3004);
        do_instr(jw(26'hC04),  1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1, 32'h0000_3010);
        do_instr(bw(16'hFFFC), 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 1'b1, 32'h0000_3014);
        do_instr(jw(26'hC04),  1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 32'h0000_3010);
        do_instr(bw(16'h0002), 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 32'h0000_301C);
        do_instr(jw(26'h0),    1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 32'h0000_0000);
        do_instr(bw(16'hFFF0), 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 32'hFFFF_FFC4);
        do_instr(bw(16'h000D), 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 32'hFFFF_FFFC);
        do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0000_0000);
        do_instr(bw(16'hFFF0), 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFC4);
        do_instr(jw(26'h100),  1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 32'hF000_0400);
        do_instr(bw(16'h0004), 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'hF000_0414);

        for (int i = 0; i < 40; i++)
            do_instr(rnd_word(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b0, 32'd0);

        do_instr(SYSCALL_WORD, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
        `ifdef IFU_HALT_EN
        for (int i = 0; i < 6; i++) begin
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            imem_ack    = 1'($urandom);
            instr_ready = 1'($urandom);
            tick();
        end
        imem_ack = 1'b0;
        do_reset(1, 1'b0);
        `endif
        do_instr(rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'd0);

        do_reset(1, 1'b1);
        do_instr(rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, RST_PC + 32'd4);
        do_instr(rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, RST_PC + 32'd8);

        repeat (2) tick();
        chk("fetch_q_drained", 32'(exp_fetch_q.size()), 32'd0);
        chk("issue_q_drained", 32'(exp_issue_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch stage that supplies the op/func stream to the control decoder and consumes its branch/jump decisions. Holds the PC, issues requests to an instruction memory with variable-latency ack, presents one instruction at a time to the datapath with a valid/ready handshake, and computes the next PC from the decoder's Branch_eq/Branch_ne/Jump outputs and the ALU zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  synchronous, active-low reset
- imem_req  output  1  instruction memory read request
- imem_addr  output  32  word-aligned read address, equals current PC
- imem_ack  input  1  read data valid on imem_rdata this cycle
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr/pc_out hold a fetched instruction
- instr_ready  input  1  datapath accepts the instruction this cycle
- instr  output  32  instruction word to decoder (op = [31:26], func = [5:0])
- pc_out  output  32  address of instr
- branch_eq, branch_ne, jump  input  1 each  decoder outputs for instr, valid while instr_valid
- zero  input  1  ALU zero flag for instr, valid while instr_valid
- halted  output  1  fetch stopped (only with IFU_HALT_EN)

## Operation
- States: FETCH (imem_req=1, wait imem_ack), ISSUE (instr_valid=1, wait instr_ready), HALT (macro only).
- FETCH: imem_addr = PC, stable until ack. On imem_ack: capture imem_rdata into instr, pc_out <= PC, go ISSUE.
- ISSUE: instr/pc_out held stable. On instr_valid && instr_ready: PC <= next PC, go FETCH.
- Next PC, pc4 = pc_out + 4 (mod 2^32):
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}; jump has priority over branch.
  - taken = (branch_eq & zero) | (branch_ne & ~zero): pc4 + (sign_extend(instr[15:0]) << 2), 32-bit wrap.
  - otherwise pc4.
- branch_eq and branch_ne both 1: taken evaluates per formula, i.e. always taken.
- imem_ack outside FETCH ignored. imem_rdata sampled only when imem_ack=1 in FETCH.
- PC bits [1:0] always 0; arithmetic never produces nonzero low bits.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.

## Timing
- Reset (rst_n=0 at a clk edge): state FETCH, PC = RESET_PC, instr = 0, pc_out = 0, instr_valid = 0, halted = 0. imem_req = 1 with imem_addr = RESET_PC from the first cycle after reset is sampled.
- imem_req is a Moore output (1 in FETCH); ack allowed in the same cycle as first req (zero wait) or any later cycle.
- Ack at edge N -> instr_valid = 1 from cycle N+1.
- Handshake at edge M -> instr_valid = 0 and imem_req = 1 with new address from cycle M+1. Minimum 2 cycles per instruction.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-fetch or mid-issue: outstanding request abandoned, any ack in the reset cycle discarded, no PC update.

## Configuration
- IFU_HALT_EN defined: accepting instr == 32'h0000_000C (syscall) moves to HALT instead of FETCH; HALT: imem_req=0, instr_valid=0, halted=1, leaves only via reset. PC still updated to pc4.
- Undefined: syscall treated as an ordinary instruction (next PC = pc4); halted tied 0; no HALT state.

## Structure
- Shared package cpu_pkg: fetch state enum, SYSCALL_WORD constant (32'h0000_000C), instruction field widths/positions (op, func, imm16, target26).
- One combinational sub-module npc_calc: inputs pc_out, instr, branch_eq, branch_ne, jump, zero; output next PC. State register, PC and holding registers stay in instr_fetch_unit.

## Test plan
- Reset, RESET_PC=32'h0000_3000, zero-wait ack, instr_ready=1, no branches -> imem_addr sequence 3000, 3004, 3008, one instruction every 2 cycles.
- Ack delayed 3 cycles -> imem_req and imem_addr held 3 cycles; instr_valid stays 0; instr_ready held 1 has no effect.
- pc_out=32'h0000_3010, branch_eq=1, zero=1, imm16=16'hFFFC -> next imem_addr 32'h0000_3004; same with zero=0 -> 32'h0000_3014; branch_ne=1, zero=0, imm16=16'h0002 -> 32'h0000_301C.
- pc_out=32'h8000_0040, jump=1, instr[25:0]=26'h0000100, branch_eq=1, zero=1 -> next imem_addr 32'h8000_0400.
- instr_ready low 5 cycles in ISSUE -> instr/pc_out stable, imem_req=0; rst_n=0 for one cycle while in FETCH with ack in that cycle -> data dropped, restart at RESET_PC.
- IFU_HALT_EN: fetch syscall, accept -> halted=1, imem_req=0 indefinitely; without macro -> fetch continues at pc4.
